// File: rtl/spi_master.sv
// SPI master: configurable word width and sck divider, MSB first.
// Ports: clk, rst_n (sync, active-low), start, tx_data, busy, done,
// rx_data, sck, ena (active-low select), dout, din.
// Optional macro SPI_MASTER_MODE_SEL_EN adds cpol/cpha mode inputs;
// without it the core is fixed to mode 0.
module spi_master #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
`ifdef SPI_MASTER_MODE_SEL_EN
  input  logic              cpol,
  input  logic              cpha,
`endif
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sck,
  output logic              ena,
  output logic              dout,
  input  logic              din
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    XFER,
    TRAIL
  } state_t;

  logic cpol_in;
  logic cpha_in;

`ifdef SPI_MASTER_MODE_SEL_EN
  assign cpol_in = cpol;
  assign cpha_in = cpha;
`else
  assign cpol_in = 1'b0;
  assign cpha_in = 1'b0;
`endif

  state_t            state, state_n;
  logic [7:0]        div, div_n;
  logic [BW-1:0]     bit_cnt, bit_n;
  logic              half, half_n;
  logic              fin, fin_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic              pol, pol_n;
  logic              pha, pha_n;
  logic              sck_n, ena_n, dout_n;
  logic              busy_n, done_n;
  logic [DATA_W-1:0] rx_n;
  logic              tick;
  logic              do_tog;
  logic              samp;

  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      div     <= '0;
      bit_cnt <= '0;
      half    <= 1'b0;
      fin     <= 1'b0;
      sh      <= '0;
      pol     <= cpol_in;
      pha     <= cpha_in;
      sck     <= cpol_in;
      ena     <= 1'b1;
      dout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
    end else begin
      state   <= state_n;
      div     <= div_n;
      bit_cnt <= bit_n;
      half    <= half_n;
      fin     <= fin_n;
      sh      <= sh_n;
      pol     <= pol_n;
      pha     <= pha_n;
      sck     <= sck_n;
      ena     <= ena_n;
      dout    <= dout_n;
      busy    <= busy_n;
      done    <= done_n;
      rx_data <= rx_n;
    end
  end

  always_comb begin
    state_n = state;
    div_n   = div;
    bit_n   = bit_cnt;
    half_n  = half;
    fin_n   = fin;
    sh_n    = sh;
    pol_n   = pol;
    pha_n   = pha;
    sck_n   = sck;
    ena_n   = ena;
    dout_n  = dout;
    busy_n  = busy;
    done_n  = 1'b0;
    rx_n    = rx_data;
    do_tog  = 1'b0;
    samp    = 1'b0;

    unique case (state)
      IDLE: begin
        ena_n  = 1'b1;
        busy_n = 1'b0;
        dout_n = 1'b0;
        sck_n  = cpol_in;
        div_n  = '0;
        bit_n  = '0;
        half_n = 1'b0;
        fin_n  = 1'b0;
        if (start) begin
          sh_n    = tx_data;
          pol_n   = cpol_in;
          pha_n   = cpha_in;
          ena_n   = 1'b0;
          busy_n  = 1'b1;
          dout_n  = cpha_in ? 1'b0 : tx_data[DATA_W-1];
          state_n = LEAD;
        end
      end
      LEAD: begin
        div_n = div + 8'd1;
        if (tick) begin
          div_n   = '0;
          do_tog  = 1'b1;
          state_n = XFER;
        end
      end
      XFER: begin
        div_n = div + 8'd1;
        if (tick) begin
          div_n = '0;
          if (fin) begin
            state_n = TRAIL;
          end else begin
            do_tog = 1'b1;
          end
        end
      end
      TRAIL: begin
        div_n = div + 8'd1;
        if (tick) begin
          div_n   = '0;
          ena_n   = 1'b1;
          dout_n  = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          rx_n    = sh;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // half=0 marks an odd (leading) toggle, half=1 an even one.
    if (do_tog) begin
      sck_n = ~sck;
      samp  = pha ? half : ~half;
      if (samp) begin
        sh_n = {sh[DATA_W-2:0], din};
      end
      if (pha && !half) begin
        dout_n = sh[DATA_W-1];
      end
      if (!pha && half && (bit_cnt != BIT_LAST)) begin
        dout_n = sh[DATA_W-1];
      end
      if (!half) begin
        half_n = 1'b1;
      end else begin
        half_n = 1'b0;
        if (bit_cnt == BIT_LAST) begin
          fin_n = 1'b1;
        end else begin
          bit_n = bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter DATA_W, default 8: bits per transfer, MSB first.
REQ-002 SHALL have parameter CLK_DIV, default 4: clk cycles per sck half-period, legal values 2 to 255.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1: transfer request, sampled only in IDLE.
REQ-006 SHALL have port tx_data, input, DATA_W: word to send, captured when start is accepted.
REQ-007 SHALL have port busy, output, 1: high from the cycle after acceptance until done.
REQ-008 SHALL have port done, output, 1: one-cycle pulse at end of transfer.
REQ-009 SHALL have port rx_data, output, DATA_W: last received word, held until next done.
REQ-010 SHALL have port sck, output, 1: SPI serial clock to slave.
REQ-011 SHALL have port ena, output, 1: slave select, active-low, idle high.
REQ-012 SHALL have port dout, output, 1: serial data to slave din.
REQ-013 SHALL have port din, input, 1: serial data from slave dout.

Function
REQ-014 SHALL implement FSM states IDLE, LEAD, XFER, TRAIL; registered outputs only.
REQ-015 IDLE: ena=1, sck=CPOL, busy=0; start=1 -> latch tx_data into shift register, ena=0, go LEAD.
REQ-016 LEAD SHALL last CLK_DIV cycles with sck=CPOL; if CPHA=0, dout=tx_data[DATA_W-1] from LEAD entry.
REQ-017 XFER SHALL produce exactly 2*DATA_W sck toggles, one per CLK_DIV cycles; first toggle at LEAD exit.
REQ-018 CPHA=0: din SHALL be sampled on odd toggles (leading edges), and the next bit SHALL be shifted onto dout on even toggles except the last.
REQ-019 CPHA=1: the next bit SHALL be shifted onto dout on odd toggles, and din SHALL be sampled on even toggles.
REQ-020 Received bits SHALL enter the shift register LSB, MSB-first order; the bit counter SHALL count 0..DATA_W-1 without wrap.
REQ-021 After the last toggle, sck SHALL equal CPOL; TRAIL SHALL hold ena=0 for CLK_DIV cycles.
REQ-022 On TRAIL exit, in the same cycle: ena=1, rx_data updated, done=1, busy=0, and the FSM SHALL return to IDLE.
REQ-023 start during LEAD/XFER/TRAIL SHALL be ignored and not queued; tx_data changes after acceptance SHALL have no effect.
REQ-024 start high in the IDLE cycle following done SHALL begin a new transfer, with ena high for at least one cycle between transfers.
REQ-025 dout SHALL be 0 while ena=1.
REQ-026 Total latency, start accept to done, SHALL be (2*DATA_W+2)*CLK_DIV cycles.

Reset
REQ-027 rst_n=0 at a clk edge SHALL force IDLE, with sck=CPOL, ena=1, dout=0, busy=0, done=0, rx_data=0, bit counter=0, divider=0.
REQ-028 Reset mid-transfer SHALL abort immediately with no done pulse; rx_data SHALL read 0.

Configuration
REQ-029 Macro SPI_MASTER_MODE_SEL_EN defined: input ports cpol and cpha (1 bit each) SHALL be added and sampled at start acceptance, then held for the transfer.
REQ-030 Macro SPI_MASTER_MODE_SEL_EN undefined: no cpol/cpha ports; CPOL=0 and CPHA=0 (mode 0) SHALL be fixed.

Verification
REQ-031 Mode 0, CLK_DIV=4, tx_data=0xB2, din looped from dout -> dout bit sequence 1,0,1,1,0,0,1,0, rx_data=0xB2, done exactly 72 cycles after accept.
REQ-032 Mode 0, din tied 1, tx_data=0x00 -> 8 rising sck edges while ena=0, rx_data=0xFF, sck=0 and ena=1 after done.
REQ-033 With SPI_MASTER_MODE_SEL_EN, cpol=1, cpha=1, slave model returns 0x5A -> sck idles high, dout changes on falling edges, rx_data=0x5A.
REQ-034 start pulsed mid-XFER, then back-to-back starts 0x11 and 0x22 -> mid-XFER start ignored; two done pulses, ena high at least one cycle between transfers.
REQ-035 rst_n=0 after 3 sck toggles -> next cycle ena=1, sck=CPOL, busy=0, no done pulse, rx_data=0.
